// File: rtl/xyz_pkg.sv
// Shared definitions for the x/y/z bundle interface.
// Both the bundle writer and the bundle reader import this package.
//   FIELD_W   : width of each bundle field
//   xyz_t     : packed x/y/z triple, each field in [FIELD_W-1:0] order
//   map_field : converts an ascending [0:FIELD_W-1] writer field into the
//               reader's descending order, keeping bit k at index k
//   fold_xyz  : x ^ y ^ z of one triple, the checksum contribution
package xyz_pkg;

  localparam int unsigned FIELD_W = 8;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] z;
  } xyz_t;

  // A plain vector assignment would connect by position (v[0] -> r[7]).
  // The bundle contract is by index, so each bit is copied explicitly.
  function automatic logic [FIELD_W-1:0] map_field(input logic [0:FIELD_W-1] v);
    logic [FIELD_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < FIELD_W; k++) begin
      r[k] = v[k];
    end
    return r;
  endfunction

  function automatic logic [FIELD_W-1:0] fold_xyz(input xyz_t t);
    return t.x ^ t.y ^ t.z;
  endfunction

endpackage

// File: rtl/xyz_fifo.sv
// Storage for buffered x/y/z triples with a registered head entry.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   push_i   : write request (ignored when full unless a pop occurs too)
//   wdata_i  : triple to write
//   pop_i    : release request for the head (ignored when empty)
//   rdata_o  : head triple, driven directly from a register
//   valid_o  : at least one triple is buffered
//   full_o   : DEPTH triples are buffered
module xyz_fifo
  import xyz_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  xyz_t wdata_i,
  input  logic pop_i,
  output xyz_t rdata_o,
  output logic valid_o,
  output logic full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  xyz_t        mem_q [DEPTH];
  xyz_t        head_q, head_d;
  logic        valid_q, valid_d;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = head_q;
    // The head register tracks the entry at the next read pointer. When that
    // entry is the one being written this cycle it is not yet in memory, so
    // it is taken from the write data instead.
    if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata_i;
    end else if (valid_d) begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Entries are only observed through the pointers, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign full_o  = full;

endmodule

// File: rtl/xyz_bundle_reader.sv
// Bundle reader: buffers x/y/z triples from the bundle writer, presents the
// oldest one downstream, and keeps an accepted-triple count and an XOR
// checksum of every accepted triple.
// Ports:
//   i_clk, i_rst_n     : clock (rising edge), asynchronous active-low reset
//   i_x, i_y, i_z      : writer fields, ascending [0:7] order
//   i_valid / o_ready  : upstream handshake
//   o_a, o_b, o_c      : head x/y/z in [7:0] order, o_a[k] = x[k]
//   o_valid / i_ready  : downstream handshake
//   o_count            : accepted triples, wraps modulo 2**CNT_W
//   o_xsum             : running XOR of x^y^z over accepted triples
module xyz_bundle_reader
  import xyz_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [0:FIELD_W-1]   i_x,
  input  logic [0:FIELD_W-1]   i_y,
  input  logic [0:FIELD_W-1]   i_z,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [FIELD_W-1:0]   o_a,
  output logic [FIELD_W-1:0]   o_b,
  output logic [FIELD_W-1:0]   o_c,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CNT_W-1:0]     o_count,
  output logic [FIELD_W-1:0]   o_xsum
);

  xyz_t in_triple;
  xyz_t head;
  logic fifo_valid;
  logic fifo_full;
  logic push;
  logic pop;

  // Held low through reset and set by the first edge afterwards, so the
  // reader never advertises space while reset is asserted.
  logic rdy_en_q;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [FIELD_W-1:0] xsum_q, xsum_d;

  always_comb begin
    in_triple.x = map_field(i_x);
    in_triple.y = map_field(i_y);
    in_triple.z = map_field(i_z);
  end

  assign pop     = fifo_valid && i_ready;
  assign o_ready = rdy_en_q && (!fifo_full || pop);
  assign push    = i_valid && o_ready;

  xyz_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .wdata_i (in_triple),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  always_comb begin
    count_d = count_q;
    xsum_d  = xsum_q;
    if (push) begin
      count_d = count_q + CNT_W'(1);
      xsum_d  = xsum_q ^ fold_xyz(in_triple);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_en_q <= 1'b0;
      count_q  <= '0;
      xsum_q   <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      count_q  <= count_d;
      xsum_q   <= xsum_d;
    end
  end

  assign o_a     = head.x;
  assign o_b     = head.y;
  assign o_c     = head.z;
  assign o_valid = fifo_valid;
  assign o_count = count_q;
  assign o_xsum  = xsum_q;

endmodule

// File: tb/tb_xyz_bundle_reader.sv
// Self-checking bench for xyz_bundle_reader: directed bundle cases plus
// randomized traffic compared against a queue-based reference model.
module tb_xyz_bundle_reader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [0:7]       x, y, z;
  logic             vin;
  logic             rdy_in;
  logic             o_ready;
  logic [7:0]       o_a, o_b, o_c;
  logic             o_valid;
  logic [CNT_W-1:0] o_count;
  logic [7:0]       o_xsum;

  xyz_bundle_reader #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_x     (x),
    .i_y     (y),
    .i_z     (z),
    .i_valid (vin),
    .o_ready (o_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_valid (o_valid),
    .i_ready (rdy_in),
    .o_count (o_count),
    .o_xsum  (o_xsum)
  );

  // Reference model: a queue of expected head values plus plain counters.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } ent_t;

  ent_t        q[$];
  int unsigned m_count;
  logic [7:0]  m_xsum;
  bit          m_run;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output bit k equals input bit k: reverse the ascending stream.
  function automatic logic [7:0] fwd(input logic [0:7] v);
    logic [7:0] r;
    r = {<<{v}};
    return r;
  endfunction

  function automatic bit m_ready();
    return m_run && ((q.size() < DEPTH) || (q.size() > 0 && rdy_in));
  endfunction

  task automatic compare_all(input string ph);
    check({ph, ".rdy"}, 32'(o_ready), 32'(m_ready()));
    check({ph, ".vld"}, 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({ph, ".a"}, 32'(o_a), 32'(q[0].a));
      check({ph, ".b"}, 32'(o_b), 32'(q[0].b));
      check({ph, ".c"}, 32'(o_c), 32'(q[0].c));
    end
    check({ph, ".cnt"}, 32'(o_count), m_count % (32'd1 << CNT_W));
    check({ph, ".xs"}, 32'(o_xsum), 32'(m_xsum));
  endtask

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic step(input bit chk, input string ph);
    bit do_push, do_pop;
    #1;
    if (chk) compare_all(ph);
    do_push = vin && m_ready();
    do_pop  = (q.size() != 0) && rdy_in;
    @(posedge clk);
    if (do_pop) q.delete(0);
    if (do_push) begin
      q.push_back('{fwd(x), fwd(y), fwd(z)});
      m_count++;
      m_xsum ^= fwd(x) ^ fwd(y) ^ fwd(z);
    end
    if (rst_n) m_run = 1'b1;
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the cleared outputs before
  // any edge arrives; releases at the next falling edge.
  task automatic do_reset(input string ph);
    #2;
    rst_n  = 1'b0;
    vin    = 1'b0;
    rdy_in = 1'b0;
    q.delete();
    m_count = 0;
    m_xsum  = '0;
    m_run   = 1'b0;
    #1;
    check({ph, ".rst_vld"}, 32'(o_valid), 32'd0);
    check({ph, ".rst_rdy"}, 32'(o_ready), 32'd0);
    check({ph, ".rst_a"},   32'(o_a),     32'd0);
    check({ph, ".rst_b"},   32'(o_b),     32'd0);
    check({ph, ".rst_c"},   32'(o_c),     32'd0);
    check({ph, ".rst_cnt"}, 32'(o_count), 32'd0);
    check({ph, ".rst_xs"},  32'(o_xsum),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned iter;
    rst_n  = 1'b0;
    vin    = 1'b0;
    rdy_in = 1'b0;
    x = '0; y = '0; z = '0;
    m_count = 0; m_xsum = '0; m_run = 1'b0;

    do_reset("init");

    // Single triple, latency one cycle; first cycle after release not ready.
    rdy_in = 1'b1; vin = 1'b1;
    x = 8'hFF; y = 8'h00; z = 8'hFF;
    step(1, "one_pre");
    step(1, "one_acc");
    vin = 1'b0;
    #1;
    check("one.vld", 32'(o_valid), 32'd1);
    check("one.a",   32'(o_a),     32'hFF);
    check("one.b",   32'(o_b),     32'h00);
    check("one.c",   32'(o_c),     32'hFF);
    check("one.cnt", 32'(o_count), 32'd1);
    check("one.xs",  32'(o_xsum),  32'h00);
    step(1, "one_drain");

    // Index mapping: ascending index 7 lands on o_a[7], index 0 on o_a[0].
    vin = 1'b1; x = 8'h01; y = 8'h00; z = 8'h00;
    step(1, "map1");
    #1;
    check("map.idx7", 32'(o_a), 32'h80);
    x = 8'h80;
    step(1, "map2");
    vin = 1'b0;
    #1;
    check("map.idx0", 32'(o_a), 32'h01);
    step(1, "map_drain");

    // Fill to full with the consumer stalled, then drain in order.
    do_reset("fill");
    step(1, "fill_wake");
    for (int i = 1; i <= 4; i++) begin
      vin = 1'b1; x = 8'(i); y = 8'(i + 16); z = 8'(i + 32);
      step(1, "fill");
    end
    #1;
    check("fill.full_rdy", 32'(o_ready), 32'd0);
    x = 8'd5;
    step(1, "fill_5th");
    vin = 1'b0; rdy_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("fill.order", 32'(o_a), 32'(fwd(8'(i))));
      step(1, "fill_drain");
    end
    check("fill.cnt", 32'(o_count), 32'd4);

    // Full buffer with push and pop together: new triple queues behind three.
    rdy_in = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      vin = 1'b1; x = 8'(i); y = 8'(i); z = 8'(i);
      step(1, "ss_fill");
    end
    rdy_in = 1'b1; x = 8'd15; y = 8'd15; z = 8'd15;
    step(1, "ss_both");
    vin = 1'b0; rdy_in = 1'b0;
    #1;
    check("ss.still_full", 32'(o_ready), 32'd0);
    rdy_in = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      #1;
      check("ss.order", 32'(o_a), 32'(fwd(8'(i))));
      step(1, "ss_drain");
    end

    // Reset in the middle of traffic with three triples buffered.
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1; x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      step(1, "mid_fill");
    end
    do_reset("mid");
    for (int i = 0; i < 3; i++) step(1, "mid_after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      vin    = 1'($urandom_range(0, 1));
      rdy_in = ($urandom_range(0, 3) != 0);
      x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      step(1, "rnd");
    end

    // Counter wrap: 2**CNT_W accepted triples bring the count back to zero.
    do_reset("wrap");
    vin = 1'b1; rdy_in = 1'b1;
    iter = 0;
    while (m_count < 65536 && iter < 70000) begin
      x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      step((iter % 8192) == 0, "wrap");
      iter++;
    end
    check("wrap.pushes", m_count, 32'd65536);
    vin = 1'b0;
    #1;
    check("wrap.cnt_zero", 32'(o_count), 32'd0);
    check("wrap.xs", 32'(o_xsum), 32'(m_xsum));
    step(1, "wrap_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
